// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl_if
// Description : Button / command bundle between the board push-buttons and
//               the stopwatch command inputs.
//                 btn_start, btn_stop, btn_lap : raw buttons, async, active-high
//                 sw1, sw2, sw3                : start / stop / lap-clear pulses
//                 mode[1:0]                    : shadow state (00 IDLE, 01 COUNT,
//                                                10 LAP, 11 STOP)
//               master : button/board side (drives buttons, observes commands)
//               slave  : stopwatch_ctrl side
// Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_ctrl_if;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_lap;
    logic       sw1;
    logic       sw2;
    logic       sw3;
    logic [1:0] mode;

    modport master (
        output btn_start, btn_stop, btn_lap,
        input  sw1, sw2, sw3, mode
    );

    modport slave (
        input  btn_start, btn_stop, btn_lap,
        output sw1, sw2, sw3, mode
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch front-end controller. Synchronizes and debounces
//               three raw push-buttons, turns debounced rising edges into
//               press events, arbitrates simultaneous events
//               (stop > start > lap), filters commands that are illegal in the
//               shadow stopwatch state and issues single-cycle pulses.
// Ports       : clk  - system clock
//               rst  - synchronous reset, active-low
//               bus  - stopwatch_ctrl_if.slave (buttons in, sw1/sw2/sw3 and
//                      mode out, all outputs registered)
// Parameters  : DEB_CYCLES - stable synchronized samples to accept a change
//               DEB_W      - debounce counter width (holds DEB_CYCLES-1)
// Option      : SWCTRL_PEND_EN - when defined, losing simultaneous events
//               are held in per-button pending bits and serviced later.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int DEB_W      = 20
) (
    input  wire logic         clk,
    input  wire logic         rst,
    stopwatch_ctrl_if.slave   bus
);

    // Button indices inside the per-button vectors
    localparam int c_start = 0;
    localparam int c_stop  = 1;
    localparam int c_lap   = 2;

    localparam logic [DEB_W-1:0] c_deb_max = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_LAP   = 2'b10,
        ST_STOP  = 2'b11
    } state_t;

    logic [2:0] w_btn;
    logic [2:0] w_evt;     // one-cycle press events, one per button
    logic [2:0] w_req;     // candidates for arbitration this cycle
    logic [2:0] w_win;     // one-hot arbitration winner

    state_t     r_state;
    logic       r_sw1;
    logic       r_sw2;
    logic       r_sw3;

    assign w_btn = {bus.btn_lap, bus.btn_stop, bus.btn_start};

    // ------------------------------------------------------------------------
    // Per-button synchronizer, debouncer and press-event detector
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic             r_s1;
        logic             r_s2;
        logic             r_deb;
        logic             r_deb_d;
        logic             r_evt;
        logic [DEB_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_deb   <= 1'b0;
                r_deb_d <= 1'b0;
                r_evt   <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1    <= w_btn[gi];
                r_s2    <= r_s1;
                r_deb_d <= r_deb;
                // Registered edge keeps the event aligned one cycle after the
                // debounced level settles.
                r_evt   <= r_deb & ~r_deb_d;
                if (r_s2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_deb_max) begin
                    r_deb <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DEB_W'(1);
                end
            end
        end

        assign w_evt[gi] = r_evt;
    end

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
`ifdef SWCTRL_PEND_EN
    logic [2:0] r_pend;
    logic [2:0] w_pend_nxt;

    always_comb begin
        w_pend_nxt = r_pend;
        if (|w_evt) begin
            // Fresh events take precedence; losers (and any repeat of an
            // already pending button) fold into the pending bits.
            w_req      = w_evt;
            w_pend_nxt = r_pend | w_evt;
        end else begin
            w_req = r_pend;
        end
        w_win = 3'b000;
        if (w_req[c_stop])       w_win[c_stop]  = 1'b1;
        else if (w_req[c_start]) w_win[c_start] = 1'b1;
        else if (w_req[c_lap])   w_win[c_lap]   = 1'b1;
        // Winner is consumed whether or not it turns out to be legal.
        w_pend_nxt = w_pend_nxt & ~w_win;
    end
`else
    always_comb begin
        w_req = w_evt;
        w_win = 3'b000;
        if (w_req[c_stop])       w_win[c_stop]  = 1'b1;
        else if (w_req[c_start]) w_win[c_start] = 1'b1;
        else if (w_req[c_lap])   w_win[c_lap]   = 1'b1;
    end
`endif

    // ------------------------------------------------------------------------
    // Shadow state machine with registered command pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_sw1   <= 1'b0;
            r_sw2   <= 1'b0;
            r_sw3   <= 1'b0;
`ifdef SWCTRL_PEND_EN
            r_pend  <= 3'b000;
`endif
        end else begin
            r_sw1 <= 1'b0;
            r_sw2 <= 1'b0;
            r_sw3 <= 1'b0;
`ifdef SWCTRL_PEND_EN
            r_pend <= w_pend_nxt;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_win[c_start]) begin
                        r_state <= ST_COUNT;
                        r_sw1   <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (w_win[c_stop]) begin
                        r_state <= ST_STOP;
                        r_sw2   <= 1'b1;
                    end else if (w_win[c_lap]) begin
                        r_state <= ST_LAP;
                        r_sw3   <= 1'b1;
                    end
                end
                ST_LAP: begin
                    if (w_win[c_stop]) begin
                        r_state <= ST_STOP;
                        r_sw2   <= 1'b1;
                    end else if (w_win[c_start]) begin
                        r_state <= ST_COUNT;
                        r_sw1   <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_win[c_start]) begin
                        r_state <= ST_COUNT;
                        r_sw1   <= 1'b1;
                    end else if (w_win[c_lap]) begin
                        r_state <= ST_IDLE;
                        r_sw3   <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sw1  = r_sw1;
    assign bus.sw2  = r_sw2;
    assign bus.sw3  = r_sw3;
    assign bus.mode = r_state;

endmodule
`default_nettype wire
